// File: rtl/conv_pool_stage_param.sv
// Post-convolution stage: grouped psum accumulation, ReLU/shift/saturate, then 2x2 stride-2
// max/average pooling across NUM_CH channels, emitting pooled-memory write beats.
module conv_pool_stage_param #(
    parameter int NUM_CH           = 2,
    parameter int GROUP_SIZE       = 3,
    parameter int ACCUM_DATA_WIDTH = 32,
    parameter int DATA_WIDTH       = 8,
    parameter int FRAC_SHIFT       = 0,
    parameter int OUT_W            = 4,
    parameter int OUT_H            = 4,
    parameter int POOL_ADDR_WIDTH  = 8
) (
    input  logic                                            clock,
    input  logic                                            reset,
    input  logic                                            start,
    input  logic                                            pool_mode,
    input  logic                                            relu_en,
    input  logic                                            in_valid,
    input  logic [ACCUM_DATA_WIDTH*NUM_CH*GROUP_SIZE-1:0]   psum_all,
    output logic                                            wr_en,
    output logic [POOL_ADDR_WIDTH-1:0]                      wr_addr,
    output logic [DATA_WIDTH*NUM_CH-1:0]                    wr_data,
    output logic                                            busy,
    output logic                                            done,
    output logic                                            sat_flag
);
    localparam int NUM_DSP = NUM_CH * GROUP_SIZE;
    localparam int SUM_W   = ACCUM_DATA_WIDTH + $clog2(GROUP_SIZE);
    localparam int PW      = DATA_WIDTH + 2;
    localparam int COL_W   = $clog2(OUT_W);
    localparam int ROW_W   = $clog2(OUT_H);
    localparam int BIDX_W  = (OUT_W > 2) ? $clog2(OUT_W / 2) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(OUT_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(OUT_H - 1);
    localparam logic signed [SUM_W-1:0] SAT_MAX = {{(SUM_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN = {{(SUM_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    state_t r_state, w_next;

    logic                                r_mode, r_relu, r_sat;
    logic                                r_s1_valid, r_s2_valid;
    logic signed [SUM_W-1:0]             r_s1_sum [NUM_CH];
    logic signed [DATA_WIDTH-1:0]        r_s2_val [NUM_CH];
    logic signed [DATA_WIDTH-1:0]        r_hold   [NUM_CH];
    logic signed [PW-1:0]                r_rowbuf [NUM_CH][OUT_W/2];
    logic [COL_W-1:0]                    r_col;
    logic [ROW_W-1:0]                    r_row;
    logic [POOL_ADDR_WIDTH-1:0]          r_addr, r_wr_addr;
    logic [DATA_WIDTH*NUM_CH-1:0]        r_wr_data;
    logic                                r_wr_en, r_last_wr;

    logic signed [ACCUM_DATA_WIDTH-1:0]  w_psum  [NUM_DSP];
    logic signed [SUM_W-1:0]             w_sum   [NUM_CH];
    logic signed [SUM_W-1:0]             w_relu  [NUM_CH];
    logic signed [SUM_W-1:0]             w_shift [NUM_CH];
    logic signed [DATA_WIDTH-1:0]        w_s2_val[NUM_CH];
    logic [NUM_CH-1:0]                   w_clip;
    logic signed [PW-1:0]                w_v [NUM_CH], w_h [NUM_CH];
    logic signed [PW-1:0]                w_pair [NUM_CH], w_quad [NUM_CH], w_avg [NUM_CH];
    logic signed [DATA_WIDTH-1:0]        w_out [NUM_CH];
    logic [BIDX_W-1:0]                   w_bidx;
    logic                                w_s1_take;

    assign w_s1_take = (r_state == S_RUN) && in_valid;
    assign w_bidx    = BIDX_W'(r_col >> 1);

    always_comb begin
        for (int unsigned k = 0; k < NUM_DSP; k++)
            w_psum[k] = psum_all[k*ACCUM_DATA_WIDTH +: ACCUM_DATA_WIDTH];
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            w_sum[c] = '0;
            for (int unsigned g = 0; g < GROUP_SIZE; g++)
                w_sum[c] = w_sum[c] + SUM_W'(w_psum[c*GROUP_SIZE+g]);
        end
    end

    always_comb begin
        w_clip = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            w_relu[c]  = (r_relu && r_s1_sum[c][SUM_W-1]) ? '0 : r_s1_sum[c];
            w_shift[c] = w_relu[c] >>> FRAC_SHIFT;
            w_s2_val[c] = w_shift[c][DATA_WIDTH-1:0];
            if (w_shift[c] > SAT_MAX) begin
                w_s2_val[c] = SAT_MAX[DATA_WIDTH-1:0];
                w_clip[c]   = 1'b1;
            end else if (w_shift[c] < SAT_MIN) begin
                w_s2_val[c] = SAT_MIN[DATA_WIDTH-1:0];
                w_clip[c]   = 1'b1;
            end
        end
    end

    // Pair result feeds both the rowbuf (even row) and the final 2x2 combine (odd row).
    always_comb begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            w_v[c]    = PW'(r_s2_val[c]);
            w_h[c]    = PW'(r_hold[c]);
            w_pair[c] = r_mode ? (w_h[c] + w_v[c]) : ((w_h[c] > w_v[c]) ? w_h[c] : w_v[c]);
            w_quad[c] = r_mode ? (r_rowbuf[c][w_bidx] + w_pair[c])
                               : ((r_rowbuf[c][w_bidx] > w_pair[c]) ? r_rowbuf[c][w_bidx] : w_pair[c]);
            w_avg[c]  = w_quad[c] >>> 2;
            w_out[c]  = r_mode ? w_avg[c][DATA_WIDTH-1:0] : w_quad[c][DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (r_last_wr) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            S_RUN:   busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_mode <= 1'b0; r_relu <= 1'b0; r_sat <= 1'b0;
            r_s1_valid <= 1'b0; r_s2_valid <= 1'b0;
            r_col <= '0; r_row <= '0; r_addr <= '0;
            r_wr_en <= 1'b0; r_last_wr <= 1'b0; r_wr_addr <= '0; r_wr_data <= '0;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                r_s1_sum[c] <= '0; r_s2_val[c] <= '0; r_hold[c] <= '0;
            end
        end else begin
            r_wr_en    <= 1'b0;
            r_last_wr  <= 1'b0;
            r_s1_valid <= w_s1_take;
            r_s2_valid <= r_s1_valid;
            if (w_s1_take) r_s1_sum <= w_sum;
            if (r_s1_valid) begin
                r_s2_val <= w_s2_val;
                if (|w_clip) r_sat <= 1'b1;
            end
            if (r_state == S_IDLE && start) begin
                r_mode <= pool_mode; r_relu <= relu_en; r_sat <= 1'b0;
                r_col <= '0; r_row <= '0; r_addr <= '0;
            end else if (r_s2_valid) begin
                if (!r_col[0]) begin
                    for (int unsigned c = 0; c < NUM_CH; c++) r_hold[c] <= r_s2_val[c];
                end else if (r_row[0]) begin
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= r_addr;
                    r_addr    <= r_addr + 1'b1;
                    r_last_wr <= (r_col == COL_LAST) && (r_row == ROW_LAST);
                    for (int unsigned c = 0; c < NUM_CH; c++)
                        r_wr_data[c*DATA_WIDTH +: DATA_WIDTH] <= w_out[c];
                end
                if (r_col == COL_LAST) begin
                    r_col <= '0;
                    r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset && r_s2_valid && r_col[0] && !r_row[0])
            for (int unsigned c = 0; c < NUM_CH; c++) r_rowbuf[c][w_bidx] <= w_pair[c];
    end

    assign wr_en    = r_wr_en;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign sat_flag = r_sat;
endmodule
